alu_pipe: RTL

Parametrised, two-stage pipelined data-processing unit: successor to the combinational N-bit bitwise-AND block, generalised to the ARM data-processing operation set, with NZCV flag generation, a persistent flags register and valid/ready handshakes on both sides. It sits between the register-read stage and the writeback stage of the CPU datapath. Throughput is one operation per cycle, latency two cycles, with full backpressure support.

---
 rtl/alu_pipe.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ARM-style data-processing unit with NZCV flags.
//
// Stage 1 registers the accepted operation (op, s, a, b). Stage 2 registers the
// result, write-back enable and NZCV, computed combinationally from stage 1.
// The architectural flags register is updated as an operation moves S1->S2.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    synchronous active-low reset
//   in_valid   operation presented            in_ready   operation accepted this cycle
//   in_op      4-bit ARM opcode               in_s       set-flags bit
//   in_a       operand Rn                     in_b       operand Op2
//   out_valid  result available               out_ready  consumer accepts result
//   out_result result                         out_wr     result must be written back
//   out_nzcv   flags computed for this op     flags      architectural NZCV register
module alu_pipe #(
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   in_op,
  input  logic         in_s,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_result,
  output logic         out_wr,
  output logic [3:0]   out_nzcv,
  output logic [3:0]   flags
);

  localparam logic [3:0] OpAnd = 4'b0000;
  localparam logic [3:0] OpEor = 4'b0001;
  localparam logic [3:0] OpSub = 4'b0010;
  localparam logic [3:0] OpRsb = 4'b0011;
  localparam logic [3:0] OpAdd = 4'b0100;
  localparam logic [3:0] OpTst = 4'b1000;
  localparam logic [3:0] OpCmp = 4'b1010;
  localparam logic [3:0] OpOrr = 4'b1100;
  localparam logic [3:0] OpMov = 4'b1101;
  localparam logic [3:0] OpBic = 4'b1110;
  localparam logic [3:0] OpMvn = 4'b1111;

  // Stage 1 state
  logic         s1_valid;
  logic [3:0]   s1_op;
  logic         s1_s;
  logic [N-1:0] s1_a;
  logic [N-1:0] s1_b;

  // Stage 2 valid; the S2 payload registers are the out_* ports themselves
  logic         s2_valid;

  logic         advance;
  logic [N-1:0] sub_x;
  logic [N-1:0] sub_y;
  logic [N:0]   sum_ext;
  logic [N:0]   diff_ext;
  logic [N-1:0] res_d;
  logic         c_d;
  logic         v_d;
  logic         wr_d;
  logic         set_flags;
  logic         reserved;
  logic [3:0]   nzcv_d;

  assign advance   = !s2_valid || out_ready;
  assign in_ready  = (!s1_valid || advance) && reset_n;
  assign out_valid = s2_valid;

  // RSB swaps the operands of the shared subtractor
  always_comb begin
    sub_x = s1_a;
    sub_y = s1_b;
    if (s1_op == OpRsb) begin
      sub_x = s1_b;
      sub_y = s1_a;
    end
  end

  // N+1-bit arithmetic; the top bit is the carry (ADD) or the borrow (SUB).
  assign sum_ext  = {1'b0, s1_a} + {1'b0, s1_b};
  assign diff_ext = {1'b0, sub_x} - {1'b0, sub_y};

  always_comb begin
    res_d     = '0;
    c_d       = flags[1];  // logical ops pass C and V through
    v_d       = flags[0];
    wr_d      = 1'b1;
    set_flags = s1_s;
    reserved  = 1'b0;
    case (s1_op)
      OpAnd: res_d = s1_a & s1_b;
      OpEor: res_d = s1_a ^ s1_b;
      OpOrr: res_d = s1_a | s1_b;
      OpMov: res_d = s1_b;
      OpBic: res_d = s1_a & ~s1_b;
      OpMvn: res_d = ~s1_b;
      OpTst: begin
        res_d     = s1_a & s1_b;
        wr_d      = 1'b0;
        set_flags = 1'b1;
      end
      OpAdd: begin
        res_d = sum_ext[N-1:0];
        c_d   = sum_ext[N];
        v_d   = ~(s1_a[N-1] ^ s1_b[N-1]) & (res_d[N-1] ^ s1_a[N-1]);
      end
      OpSub, OpRsb, OpCmp: begin
        res_d = diff_ext[N-1:0];
        c_d   = ~diff_ext[N];
        v_d   = (sub_x[N-1] ^ sub_y[N-1]) & (res_d[N-1] ^ sub_x[N-1]);
        if (s1_op == OpCmp) begin
          wr_d      = 1'b0;
          set_flags = 1'b1;
        end
      end
      default: begin
        reserved  = 1'b1;
        wr_d      = 1'b0;
        set_flags = 1'b0;
      end
    endcase
    nzcv_d = reserved ? 4'b0000 : {res_d[N-1], (res_d == '0), c_d, v_d};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid   <= 1'b0;
      s1_op      <= 4'b0000;
      s1_s       <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s2_valid   <= 1'b0;
      out_result <= '0;
      out_wr     <= 1'b0;
      out_nzcv   <= 4'b0000;
      flags      <= 4'b0000;
    end else begin
      // S1 is writable whenever it is empty or its content moves on this edge
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_op <= in_op;
          s1_s  <= in_s;
          s1_a  <= in_a;
          s1_b  <= in_b;
        end
      end
      if (advance) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_result <= res_d;
          out_wr     <= wr_d;
          out_nzcv   <= nzcv_d;
          if (set_flags) begin
            flags <= nzcv_d;
          end
        end
      end
    end
  end

endmodule
